// File: rtl/router_sync.sv
// Steering stage of the 1x3 router: header address latch, FIFO write/full muxing,
// per-port valid outputs and unread-port timeout flush. Optional: ROUTER_SYNC_STICKY_ERR_EN.
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
`ifdef ROUTER_SYNC_STICKY_ERR_EN
    ,
    output logic [2:0] timeout_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       soft_reset_q, soft_reset_d;
    logic [2:0]       vld;
    logic [2:0]       rd;
    logic [2:0]       stall;

    assign vld = {~empty_2, ~empty_1, ~empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];

    always_comb begin
        addr_d       = addr_q;
        soft_reset_d = 3'b000;
        stall        = vld & ~rd;
        if (detect_add) begin
            addr_d = data_in;
        end
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (stall[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Steering uses the registered address, so a header written this cycle
    // only redirects writes from the next cycle on.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        if (!reset) begin
            case (addr_q)
                2'b00: begin
                    write_enb = {2'b00, write_enb_reg};
                    fifo_full = full_0;
                end
                2'b01: begin
                    write_enb = {1'b0, write_enb_reg, 1'b0};
                    fifo_full = full_1;
                end
                2'b10: begin
                    write_enb = {write_enb_reg, 2'b00};
                    fifo_full = full_2;
                end
                default: begin
                    write_enb = 3'b000;
                    fifo_full = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= 2'b11;
            soft_reset_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q       <= addr_d;
            soft_reset_q <= soft_reset_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef ROUTER_SYNC_STICKY_ERR_EN
    logic [2:0] timeout_err_q, timeout_err_d;

    always_comb begin
        timeout_err_d = timeout_err_q | soft_reset_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err_q <= 3'b000;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address steering, full muxing, valid outputs,
// timeout pulses, read/reset cancellation and (if enabled) sticky timeout errors.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_STICKY_ERR_EN
    logic [2:0] timeout_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    router_sync dut (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
`ifdef ROUTER_SYNC_STICKY_ERR_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [2:0] soft_all();
        return {soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    initial begin
        reset = 1'b1; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        #1;
        check("rst_wen_comb", write_enb, 3'b000);
        check("rst_full_comb", fifo_full, 1'b0);
        tick(2);
        reset = 1'b0;
        #1;
        check("rst_soft", soft_all(), 3'b000);
        check("rst_addr11_wen", write_enb, 3'b000);
        check("rst_addr11_full", fifo_full, 1'b0);
        check("vld_idle", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);

        // Scenario 1: latch 01 while writing; steering uses the old address
        detect_add = 1'b1; data_in = 2'b01; full_1 = 1'b0;
        #1;
        check("latch_same_cycle_wen", write_enb, 3'b000);
        tick(1);
        detect_add = 1'b0;
        #1;
        check("addr01_wen", write_enb, 3'b010);
        check("addr01_full0", fifo_full, 1'b0);
        full_1 = 1'b1;
        #1;
        check("addr01_full1", fifo_full, 1'b1);

        // Scenario 2: address 10, then 11, then 00
        detect_add = 1'b1; data_in = 2'b10; full_2 = 1'b1; full_0 = 1'b0;
        tick(1);
        detect_add = 1'b0;
        #1;
        check("addr10_full", fifo_full, 1'b1);
        check("addr10_wen", write_enb, 3'b100);
        detect_add = 1'b1; data_in = 2'b11;
        tick(1);
        detect_add = 1'b0;
        #1;
        check("addr11_full", fifo_full, 1'b0);
        check("addr11_wen", write_enb, 3'b000);
        detect_add = 1'b1; data_in = 2'b00;
        tick(1);
        detect_add = 1'b0;
        #1;
        check("addr00_wen", write_enb, 3'b001);
        check("addr00_full", fifo_full, 1'b0);
        write_enb_reg = 1'b0;
        #1;
        check("addr00_no_wreg", write_enb, 3'b000);

        // Valid outputs are a direct inversion of empty
        empty_1 = 1'b0;
        #1;
        check("vld_pattern", {vld_out_2, vld_out_1, vld_out_0}, 3'b010);
        empty_1 = 1'b1;

        // Scenario 3: port 0 stalled for 30 edges
        empty_0 = 1'b0;
        tick(29);
        check("to0_edge29", soft_all(), 3'b000);
        tick(1);
        check("to0_edge30", soft_all(), 3'b001);
        tick(1);
        check("to0_edge31", soft_all(), 3'b000);
`ifdef ROUTER_SYNC_STICKY_ERR_EN
        check("sticky_after_to0", timeout_err, 3'b001);
`endif
        empty_0 = 1'b1;
        tick(1);

        // Scenario 4: read at edge 29 cancels; full period needed afterwards
        empty_0 = 1'b0;
        tick(28);
        read_enb_0 = 1'b1;
        tick(1);
        check("rd29_no_pulse", soft_all(), 3'b000);
        read_enb_0 = 1'b0;
        tick(1);
        check("rd29_edge30", soft_all(), 3'b000);
        tick(28);
        check("rd_restart_29", soft_all(), 3'b000);
        tick(1);
        check("rd_restart_30", soft_all(), 3'b001);
        tick(1);
        check("rd_restart_31", soft_all(), 3'b000);
`ifdef ROUTER_SYNC_STICKY_ERR_EN
        check("sticky_holds", timeout_err, 3'b001);
`endif
        empty_0 = 1'b1;
        tick(1);

        // Scenario 5a: ports 1 and 2 time out together
        empty_1 = 1'b0; empty_2 = 1'b0;
        tick(29);
        check("to12_edge29", soft_all(), 3'b000);
        tick(1);
        check("to12_edge30", soft_all(), 3'b110);
        tick(1);
        check("to12_edge31", soft_all(), 3'b000);
        empty_1 = 1'b1; empty_2 = 1'b1;
        tick(1);

        // Scenario 5b: reset at stall edge 20 restarts the count
        empty_1 = 1'b0;
        tick(19);
        reset = 1'b1; write_enb_reg = 1'b1; full_0 = 1'b1;
        #1;
        check("midrst_wen_comb", write_enb, 3'b000);
        check("midrst_full_comb", fifo_full, 1'b0);
        tick(1);
        reset = 1'b0;
        #1;
        check("midrst_addr11_wen", write_enb, 3'b000);
`ifdef ROUTER_SYNC_STICKY_ERR_EN
        check("sticky_cleared", timeout_err, 3'b000);
`endif
        tick(29);
        check("midrst_edge29", soft_all(), 3'b000);
        tick(1);
        check("midrst_edge30", soft_all(), 3'b010);
        tick(1);
        check("midrst_edge31", soft_all(), 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
